// File: rtl/gpio_debounce.sv
// Pad input conditioning: synchronizer chain, shared prescaler and per-pin
// glitch filter with single-cycle rise/fall event pulses.
module gpio_debounce #(
    parameter int GPIO_DAT = 32,
    parameter int GPIO_CDC = 2,
    parameter int PRE_W    = 16,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PRE_W-1:0]    cfg_pre,
    input  logic [CNT_W-1:0]    cfg_cnt,
    input  logic [GPIO_DAT-1:0] cfg_ena,
    input  logic [GPIO_DAT-1:0] pad_i,
    output logic [GPIO_DAT-1:0] gpio_o,
    output logic [GPIO_DAT-1:0] rise,
    output logic [GPIO_DAT-1:0] fall
);

    logic [GPIO_DAT-1:0] s;

    generate
        if (GPIO_CDC == 0) begin : g_nosync
            assign s = pad_i;
        end else begin : g_sync
            logic [GPIO_DAT-1:0] sync_q [GPIO_CDC];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < GPIO_CDC; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= pad_i;
                    for (int k = 1; k < GPIO_CDC; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[GPIO_CDC-1];
        end
    endgenerate

    // Greater-or-equal compare so a lowered period wraps immediately.
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    always_comb begin
        tick  = (pre_q >= cfg_pre);
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    logic [GPIO_DAT-1:0] filt_q, filt_d;
    logic [GPIO_DAT-1:0] dly_q;
    logic [CNT_W-1:0]    cnt_q [GPIO_DAT];
    logic [CNT_W-1:0]    cnt_d [GPIO_DAT];

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < GPIO_DAT; i++) begin
            if (!cfg_ena[i]) begin
                filt_d[i] = s[i];
                cnt_d[i]  = '0;
            end else if (s[i] == filt_q[i]) begin
                // Any agreeing cycle discards partial glitch credit.
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] >= cfg_cnt) begin
                    filt_d[i] = s[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            filt_q <= '0;
            dly_q  <= '0;
            for (int i = 0; i < GPIO_DAT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            filt_q <= filt_d;
            dly_q  <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign gpio_o = filt_q;
    assign rise   = filt_q & ~dly_q;
    assign fall   = ~filt_q & dly_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: cycle-level behavioural model compared on
// every negedge, plus hand-computed latency and pulse expectations.
module tb_gpio_debounce;

    localparam int GPIO_DAT = 32;
    localparam int GPIO_CDC = 2;
    localparam int PRE_W    = 16;
    localparam int CNT_W    = 4;

    logic                clk;
    logic                rst;
    logic [PRE_W-1:0]    cfg_pre;
    logic [CNT_W-1:0]    cfg_cnt;
    logic [GPIO_DAT-1:0] cfg_ena;
    logic [GPIO_DAT-1:0] pad_i;
    logic [GPIO_DAT-1:0] gpio_o;
    logic [GPIO_DAT-1:0] rise;
    logic [GPIO_DAT-1:0] fall;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_debounce #(
        .GPIO_DAT(GPIO_DAT),
        .GPIO_CDC(GPIO_CDC),
        .PRE_W(PRE_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_pre(cfg_pre),
        .cfg_cnt(cfg_cnt),
        .cfg_ena(cfg_ena),
        .pad_i(pad_i),
        .gpio_o(gpio_o),
        .rise(rise),
        .fall(fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pad history indexed by cycle number since reset, integer counters.
    logic [GPIO_DAT-1:0] m_q, m_qd;
    logic [GPIO_DAT-1:0] m_log [8];
    int                  m_c [GPIO_DAT];
    int                  m_p;
    int                  m_n;

    always @(posedge clk or negedge rst) begin : model
        logic [GPIO_DAT-1:0] sv, nq;
        int                  nc [GPIO_DAT];
        bit                  tk;
        if (!rst) begin
            m_q  <= '0;
            m_qd <= '0;
            m_p  <= 0;
            m_n  <= 0;
            for (int i = 0; i < GPIO_DAT; i++) m_c[i] <= 0;
        end else begin
            if (GPIO_CDC == 0)        sv = pad_i;
            else if (m_n >= GPIO_CDC) sv = m_log[(m_n - GPIO_CDC) % 8];
            else                      sv = '0;
            tk = (m_p >= int'(cfg_pre));
            nq = m_q;
            nc = m_c;
            for (int i = 0; i < GPIO_DAT; i++) begin
                if (!cfg_ena[i]) begin
                    nq[i] = sv[i];
                    nc[i] = 0;
                end else if (sv[i] == m_q[i]) begin
                    nc[i] = 0;
                end else if (tk && m_c[i] >= int'(cfg_cnt)) begin
                    nq[i] = sv[i];
                    nc[i] = 0;
                end else if (tk) begin
                    nc[i] = m_c[i] + 1;
                end
            end
            m_log[m_n % 8] <= pad_i;
            m_n  <= m_n + 1;
            m_p  <= tk ? 0 : m_p + 1;
            m_q  <= nq;
            m_qd <= m_q;
            m_c  <= nc;
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (gpio_o !== m_q) begin
            n_fail++;
            $display("FAIL model_gpio t=%0t actual=%h required=%h", $time, gpio_o, m_q);
        end
        n_checks++;
        if (rise !== (m_q & ~m_qd)) begin
            n_fail++;
            $display("FAIL model_rise t=%0t actual=%h required=%h", $time, rise, m_q & ~m_qd);
        end
        n_checks++;
        if (fall !== (~m_q & m_qd)) begin
            n_fail++;
            $display("FAIL model_fall t=%0t actual=%h required=%h", $time, fall, ~m_q & m_qd);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Forces a tick on the next edge so later ticks land at known cycles.
    task automatic align_pre(input logic [PRE_W-1:0] period_m1);
        cfg_pre = '0;
        step(1);
        cfg_pre = period_m1;
    endtask

    int lat, lat0, lat31, rises, falls;

    initial begin
        rst     = 1'b0;
        cfg_pre = '0;
        cfg_cnt = '0;
        cfg_ena = '0;
        pad_i   = '0;

        // Reset hold with toggling pads, then pass-through latency.
        step(1);
        for (int n = 0; n < 6; n++) begin
            pad_i = ~pad_i;
            step(1);
            chk("rst_gpio", gpio_o, 32'h0);
            chk("rst_rise", rise, 32'h0);
            chk("rst_fall", fall, 32'h0);
        end
        pad_i = '0;
        rst   = 1'b1;
        step(4);
        pad_i[0] = 1'b1;
        step(2);
        chk("pt_gpio_t2", {31'b0, gpio_o[0]}, 32'd0);
        step(1);
        chk("pt_gpio_t3", {31'b0, gpio_o[0]}, 32'd1);
        chk("pt_rise_t3", {31'b0, rise[0]}, 32'd1);
        step(1);
        chk("pt_rise_t4", {31'b0, rise[0]}, 32'd0);
        chk("pt_gpio_t4", {31'b0, gpio_o[0]}, 32'd1);

        // Glitch rejection: 8-cycle pulse earns only 2 of 3 required ticks.
        pad_i = '0;
        step(4);
        cfg_ena = '1;
        cfg_cnt = 4'd2;
        align_pre(16'd3);
        pad_i[5] = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step(1);
            if (n == 8) pad_i[5] = 1'b0;
            chk("glitch_gpio5", {31'b0, gpio_o[5]}, 32'd0);
            chk("glitch_rise5", {31'b0, rise[5]}, 32'd0);
        end

        // Accepted transition: ticks at +4,+8,+12 edges after sync -> 12 cycles.
        align_pre(16'd3);
        pad_i[5] = 1'b1;
        lat = -1; rises = 0; falls = 0;
        for (int n = 1; n <= 40; n++) begin
            step(1);
            if (rise[5]) rises++;
            if (fall[5]) falls++;
            if (gpio_o[5] && lat < 0) lat = n;
        end
        chk("accept_latency", lat, 32'd12);
        chk("accept_rises", rises, 32'd1);
        chk("accept_falls", falls, 32'd0);
        chk("accept_level", {31'b0, gpio_o[5]}, 32'd1);

        // Boundary: cfg_pre=0, cfg_cnt=0, single-cycle pad pulse passes.
        cfg_pre = '0;
        cfg_cnt = '0;
        pad_i   = '0;
        step(6);
        pad_i[0] = 1'b1;
        step(1);
        pad_i[0] = 1'b0;
        step(2);
        chk("bnd_gpio_hi", {31'b0, gpio_o[0]}, 32'd1);
        chk("bnd_rise", {31'b0, rise[0]}, 32'd1);
        chk("bnd_nofall", {31'b0, fall[0]}, 32'd0);
        step(1);
        chk("bnd_gpio_lo", {31'b0, gpio_o[0]}, 32'd0);
        chk("bnd_fall", {31'b0, fall[0]}, 32'd1);
        chk("bnd_norise", {31'b0, rise[0]}, 32'd0);
        step(1);
        chk("bnd_fall_end", {31'b0, fall[0]}, 32'd0);

        // Mid-operation threshold change: cfg_cnt 7 -> 1 after 3 ticks.
        cfg_cnt = 4'd7;
        align_pre(16'd3);
        pad_i[1] = 1'b1;
        step(12);
        cfg_cnt = 4'd1;
        step(3);
        chk("mid_gpio1_pre", {31'b0, gpio_o[1]}, 32'd0);
        step(1);
        chk("mid_gpio1_acc", {31'b0, gpio_o[1]}, 32'd1);
        chk("mid_rise1", {31'b0, rise[1]}, 32'd1);

        // Reset mid-count while pin 1 is filtered high.
        cfg_cnt  = 4'd7;
        pad_i[1] = 1'b0;
        step(10);
        chk("mid_gpio1_held", {31'b0, gpio_o[1]}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_gpio", gpio_o, 32'h0);
        chk("rst_async_rise", rise, 32'h0);
        chk("rst_async_fall", fall, 32'h0);
        step(2);
        rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step(1);
            chk("post_rst_rise", rise, 32'h0);
            chk("post_rst_fall", fall, 32'h0);
        end

        // Multi-pin: pins 0 and 31 filtered, pin 7 pass-through.
        cfg_ena = 32'h8000_0001;
        cfg_pre = 16'd1;
        cfg_cnt = 4'd1;
        step(3);
        pad_i = 32'h8000_0081;
        lat0 = -1; lat31 = -1;
        for (int n = 1; n <= 20; n++) begin
            step(1);
            if (rise[0] && lat0 < 0) lat0 = n;
            if (rise[31] && lat31 < 0) lat31 = n;
            if (n == 2) chk("multi_pt7_t2", {31'b0, gpio_o[7]}, 32'd0);
            if (n == 3) begin
                chk("multi_pt7_t3", {31'b0, gpio_o[7]}, 32'd1);
                chk("multi_rise7", {31'b0, rise[7]}, 32'd1);
            end
        end
        chk("multi_same_cycle", lat31, lat0);
        chk("multi_lat_range", {31'b0, (lat0 == 5 || lat0 == 6)}, 32'd1);
        chk("multi_levels", gpio_o, 32'h8000_0081);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
